// File: rtl/ddr_pkg.sv
// Shared types for the DDR host request front end: request codes, timing set, queued command.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ddr_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 64;

    typedef enum logic [2:0] {
        REQ_NOP   = 3'd0,
        REQ_READ  = 3'd1,
        REQ_WRITE = 3'd2
    } req_t;

    // Active mode-register timing set
    typedef struct packed {
        logic [2:0] CL;
        logic [2:0] AL;
        logic [2:0] BL;
        logic [2:0] CWL;
        logic       RD_PRE;
        logic       WR_PRE;
    } mrs_cfg_t;

    // One queued host request
    typedef struct packed {
        req_t                  req;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } host_cmd_t;

    typedef enum logic [1:0] {
        MRS_IDLE  = 2'd0,
        MRS_DRAIN = 2'd1,
        MRS_APPLY = 2'd2
    } mrs_state_t;

    // Only READ and WRITE are ever queued; every other code is swallowed at the port
    function automatic logic is_mem_req(input logic [2:0] code);
        return (code == REQ_READ) || (code == REQ_WRITE);
    endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Single-clock FIFO of host_cmd_t entries with occupancy count.
// Latency: an entry pushed on edge N is visible at pop_dat after edge N.
// Backpressure: push is refused when full unless a pop happens the same cycle.
module ddr_req_fifo
    import ddr_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  host_cmd_t        push_dat,
    input  logic             pop,
    output host_cmd_t        pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    host_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Pop is evaluated first so a full FIFO can take a push in the cycle it pops
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/ddr_host_req_arbiter.sv
// Per-host request FIFOs, round-robin merge into one registered command stream, MRS drain/apply.
// Latency: 2 edges from host push to cmd_valid (FIFO + output register); timing set applies after drain.
// Backpressure: cmd_rdy low holds the output register; host_rdy drops on FIFO full or while an MRS drains.
// Optional: define REQ_STATS_EN to add stat_sel/stat_cnt per-host accepted-command counters.
module ddr_host_req_arbiter
    import ddr_pkg::*;
#(
    parameter int         NUM_HOSTS  = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter int         ADDR_W     = CMD_ADDR_W,
    parameter int         DATA_W     = CMD_DATA_W,
    parameter logic [2:0] DEF_CL     = 3'd5,
    parameter logic [2:0] DEF_AL     = 3'd0,
    parameter logic [2:0] DEF_BL     = 3'd0,
    parameter logic [2:0] DEF_CWL    = 3'd4,
    localparam int        HOST_W     = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic                          CK_t,
    input  logic                          reset,
    input  logic [NUM_HOSTS-1:0]          host_valid,
    input  logic [NUM_HOSTS*3-1:0]        host_req,
    input  logic [NUM_HOSTS*ADDR_W-1:0]   host_addr,
    input  logic [NUM_HOSTS*DATA_W-1:0]   host_wdata,
    output logic [NUM_HOSTS-1:0]          host_rdy,
    input  logic                          mrs_update,
    input  logic [2:0]                    new_CL,
    input  logic [2:0]                    new_AL,
    input  logic [2:0]                    new_BL,
    input  logic [2:0]                    new_CWL,
    input  logic                          new_RD_PRE,
    input  logic                          new_WR_PRE,
    output logic                          cmd_valid,
    input  logic                          cmd_rdy,
    output logic [2:0]                    cmd_req,
    output logic [ADDR_W-1:0]             cmd_addr,
    output logic [DATA_W-1:0]             cmd_wdata,
    output logic [HOST_W-1:0]             cmd_host,
    output logic [2:0]                    cfg_CL,
    output logic [2:0]                    cfg_AL,
    output logic [2:0]                    cfg_BL,
    output logic [2:0]                    cfg_CWL,
    output logic                          cfg_RD_PRE,
    output logic                          cfg_WR_PRE,
    output logic                          mrs_busy,
    output logic                          mrs_done
`ifdef REQ_STATS_EN
    ,
    input  logic [HOST_W-1:0]             stat_sel,
    output logic [15:0]                   stat_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam mrs_cfg_t DEF_CFG = '{CL: DEF_CL, AL: DEF_AL, BL: DEF_BL, CWL: DEF_CWL,
                                     RD_PRE: 1'b0, WR_PRE: 1'b0};

    host_cmd_t              fifo_din   [NUM_HOSTS];
    host_cmd_t              fifo_dout  [NUM_HOSTS];
    logic [CNT_W-1:0]       fifo_count [NUM_HOSTS];
    logic [NUM_HOSTS-1:0]   fifo_push;
    logic [NUM_HOSTS-1:0]   fifo_pop;
    logic [NUM_HOSTS-1:0]   fifo_full;
    logic [NUM_HOSTS-1:0]   fifo_empty;
    logic [NUM_HOSTS-1:0]   fifo_busy;

    logic [HOST_W-1:0]      rr_ptr_q;
    logic [HOST_W-1:0]      cand;
    logic [HOST_W-1:0]      win_idx;
    logic                   win_vld;
    logic                   load_slot;

    logic                   out_vld_q;
    host_cmd_t              out_cmd_q;
    logic [HOST_W-1:0]      out_host_q;

    mrs_state_t             state_q, state_d;
    mrs_cfg_t               cfg_q, cfg_d;
    mrs_cfg_t               shadow_q, shadow_d;
    mrs_cfg_t               new_cfg;
    logic                   accept_ok;
    logic                   drained;

    // Hosts are only accepted outside reset and while no timing change is pending
    assign accept_ok = (state_q == MRS_IDLE) && !reset;
    assign host_rdy  = ~fifo_full & {NUM_HOSTS{accept_ok}};

    // The output register refills whenever it is empty or being consumed this cycle
    assign load_slot = !out_vld_q || cmd_rdy;

    for (genvar i = 0; i < NUM_HOSTS; i++) begin : g_host
        logic [2:0] code;
        assign code         = host_req[i*3 +: 3];
        assign fifo_din[i]  = '{req:   req_t'(code),
                                addr:  host_addr[i*ADDR_W +: ADDR_W],
                                wdata: host_wdata[i*DATA_W +: DATA_W]};
        assign fifo_push[i] = host_valid[i] && host_rdy[i] && is_mem_req(code);
        assign fifo_pop[i]  = load_slot && win_vld && (win_idx == HOST_W'(i));
        assign fifo_busy[i] = (fifo_count[i] != '0);

        ddr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (CK_t),
            .rst      (reset),
            .push     (fifo_push[i]),
            .push_dat (fifo_din[i]),
            .pop      (fifo_pop[i]),
            .pop_dat  (fifo_dout[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .count    (fifo_count[i])
        );
    end

    // Round-robin pick: scan from the highest offset down so the nearest non-empty FIFO at/after rr_ptr wins
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
            cand = HOST_W'((int'(rr_ptr_q) + k) % NUM_HOSTS);
            if (!fifo_empty[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Output command register and RR pointer; fields are held while the controller stalls
    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_cmd_q  <= '0;
            out_host_q <= '0;
            rr_ptr_q   <= '0;
        end else if (load_slot) begin
            out_vld_q <= win_vld;
            if (win_vld) begin
                out_cmd_q  <= fifo_dout[win_idx];
                out_host_q <= win_idx;
                rr_ptr_q   <= (win_idx == HOST_W'(NUM_HOSTS - 1)) ? '0 : win_idx + HOST_W'(1);
            end
        end
    end

    assign cmd_valid = out_vld_q;
    assign cmd_req   = out_cmd_q.req;
    assign cmd_addr  = out_cmd_q.addr;
    assign cmd_wdata = out_cmd_q.wdata;
    assign cmd_host  = out_host_q;

    assign new_cfg = '{CL: new_CL, AL: new_AL, BL: new_BL, CWL: new_CWL,
                       RD_PRE: new_RD_PRE, WR_PRE: new_WR_PRE};
    assign drained = !(|fifo_busy) && !out_vld_q;

    // MRS state, shadow and active timing registers
    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state_q  <= MRS_IDLE;
            shadow_q <= DEF_CFG;
            cfg_q    <= DEF_CFG;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
        end
    end

    // MRS next state: capture, wait for the pipe to empty, then switch the active set
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        mrs_busy = 1'b0;
        mrs_done = 1'b0;
        case (state_q)
            MRS_IDLE: begin
                if (mrs_update) begin
                    shadow_d = new_cfg;
                    state_d  = MRS_DRAIN;
                end
            end
            MRS_DRAIN: begin
                mrs_busy = 1'b1;
                // Last update wins, including one landing on the drain-complete cycle
                if (mrs_update) shadow_d = new_cfg;
                if (drained) begin
                    cfg_d   = shadow_d;
                    state_d = MRS_APPLY;
                end
            end
            MRS_APPLY: begin
                // New set is already active this cycle; updates here are ignored
                mrs_done = 1'b1;
                state_d  = MRS_IDLE;
            end
            default: state_d = MRS_IDLE;
        endcase
    end

    assign cfg_CL     = cfg_q.CL;
    assign cfg_AL     = cfg_q.AL;
    assign cfg_BL     = cfg_q.BL;
    assign cfg_CWL    = cfg_q.CWL;
    assign cfg_RD_PRE = cfg_q.RD_PRE;
    assign cfg_WR_PRE = cfg_q.WR_PRE;

`ifdef REQ_STATS_EN
    logic [15:0] stat_q [NUM_HOSTS];

    // Saturating per-host count of commands taken by the controller
    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < NUM_HOSTS; h++) stat_q[h] <= '0;
        end else if (out_vld_q && cmd_rdy && (stat_q[out_host_q] != 16'hFFFF)) begin
            stat_q[out_host_q] <= stat_q[out_host_q] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
